// File: rtl/color_show_pkg.sv
// Shared definitions for the colour-show configuration scheduler:
// UART command bytes, scheduler FSM states and the default pattern width.
package color_show_pkg;

   localparam int DEF_PAT_W = 3;

   localparam logic [7:0] BYTE_H = 8'h48;
   localparam logic [7:0] BYTE_V = 8'h56;
   localparam logic [7:0] BYTE_U = 8'h55;
   localparam logic [7:0] BYTE_E = 8'h45;
   localparam logic [7:0] BYTE_R = 8'h52;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_FRAME,
      ST_APPLY
   } state_e;

   typedef enum logic [2:0] {
      CMD_H,
      CMD_V,
      CMD_U,
      CMD_E,
      CMD_R
   } cmd_e;

   typedef struct packed {
      logic valid;
      cmd_e cmd;
   } dec_t;

   // Unknown bytes decode as invalid and are dropped without occupying the slot.
   function automatic dec_t decode_byte(input logic [7:0] b);
      dec_t d;
      d.valid = 1'b1;
      d.cmd   = CMD_H;
      case (b)
         BYTE_H:  d.cmd = CMD_H;
         BYTE_V:  d.cmd = CMD_V;
         BYTE_U:  d.cmd = CMD_U;
         BYTE_E:  d.cmd = CMD_E;
         BYTE_R:  d.cmd = CMD_R;
         default: d.valid = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: one-cycle pulse when level goes 0->1. The history
// register tracks the level through reset so a held input yields no pulse.
module edge_rise (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic rise
);

   logic level_q;

   // NOTE: sequential state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      level_q <= level;
   end

   assign rise = level & ~level_q & ~rst;

endmodule

// File: rtl/color_cfg_sched.sv
// Collects button and UART configuration requests and applies them once per
// frame, during vertical blank, with button requests taking priority.
module color_cfg_sched
   import color_show_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             HS,
   input  logic             VS,
   input  logic             DF_UART,
   input  logic             DF_VGA,
   input  logic             frame_start,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   output logic             rx_ready,
   output logic [PAT_W-1:0] h_pat,
   output logic [PAT_W-1:0] v_pat,
   output logic             src_uart,
   output logic             vga_en,
   output logic             cfg_strobe
);

   logic h_rise, v_rise, src_rise, en_rise;

   edge_rise u_edge_h   (.clk(clk), .rst(rst), .level(HS),      .rise(h_rise));
   edge_rise u_edge_v   (.clk(clk), .rst(rst), .level(VS),      .rise(v_rise));
   edge_rise u_edge_src (.clk(clk), .rst(rst), .level(DF_UART), .rise(src_rise));
   edge_rise u_edge_en  (.clk(clk), .rst(rst), .level(DF_VGA),  .rise(en_rise));

   state_e state_q, state_d;

   logic h_inc_q, v_inc_q, src_tgl_q, en_tgl_q;
   logic h_inc_d, v_inc_d, src_tgl_d, en_tgl_d;
   logic slot_full_q, slot_full_d;
   cmd_e slot_cmd_q, slot_cmd_d;

   logic             stage_valid_q;
   logic [PAT_W-1:0] stage_h_q, stage_v_q;
   logic             stage_src_q, stage_en_q;

   logic [PAT_W-1:0] new_h, new_v;
   logic             new_src, new_en;

   logic in_apply, rx_accept, slot_conflict, slot_apply;
   logic pend_q, pend_d;
   dec_t rx_dec;

   assign rx_ready  = ~slot_full_q & ~rst;
   assign rx_accept = rx_valid & rx_ready;
   assign rx_dec    = decode_byte(rx_data);
   assign in_apply  = (state_q == ST_APPLY);

   // A queued command waits a frame when a button flag targets the same field.
   // NOTE: every always_comb output gets a default first, so no latch is inferred.
   always_comb begin
      slot_conflict = 1'b0;
      unique case (slot_cmd_q)
         CMD_H:   slot_conflict = h_inc_q;
         CMD_V:   slot_conflict = v_inc_q;
         CMD_U:   slot_conflict = src_tgl_q;
         CMD_E:   slot_conflict = en_tgl_q;
         CMD_R:   slot_conflict = h_inc_q | v_inc_q;
         default: slot_conflict = 1'b0;
      endcase
   end

   assign slot_apply = in_apply & slot_full_q & ~slot_conflict;

   // Flags are all consumed in APPLY; an edge in that same cycle re-arms them.
   assign h_inc_d   = (h_inc_q   & ~in_apply) | h_rise;
   assign v_inc_d   = (v_inc_q   & ~in_apply) | v_rise;
   assign src_tgl_d = (src_tgl_q & ~in_apply) | src_rise;
   assign en_tgl_d  = (en_tgl_q  & ~in_apply) | en_rise;

   always_comb begin
      slot_full_d = slot_full_q;
      slot_cmd_d  = slot_cmd_q;
      if (slot_apply) begin
         slot_full_d = 1'b0;
      end
      if (rx_accept && rx_dec.valid) begin
         slot_full_d = 1'b1;
         slot_cmd_d  = rx_dec.cmd;
      end
   end

   assign pend_q = h_inc_q | v_inc_q | src_tgl_q | en_tgl_q | slot_full_q;
   assign pend_d = h_inc_d | v_inc_d | src_tgl_d | en_tgl_d | slot_full_d;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:       if (pend_q) state_d = ST_WAIT_FRAME;
         ST_WAIT_FRAME: if (frame_start) state_d = ST_APPLY;
         ST_APPLY:      state_d = pend_d ? ST_WAIT_FRAME : ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      new_h   = h_pat;
      new_v   = v_pat;
      new_src = src_uart ^ src_tgl_q;
      new_en  = vga_en ^ en_tgl_q;
      if (h_inc_q) new_h = h_pat + 1'b1;
      if (v_inc_q) new_v = v_pat + 1'b1;
      if (slot_apply) begin
         unique case (slot_cmd_q)
            CMD_H:   new_h   = h_pat + 1'b1;
            CMD_V:   new_v   = v_pat + 1'b1;
            CMD_U:   new_src = ~src_uart;
            CMD_E:   new_en  = ~vga_en;
            CMD_R: begin
               new_h = '0;
               new_v = '0;
            end
            default: ;
         endcase
      end
   end

   // New values are staged in APPLY and become visible one edge later,
   // together with cfg_strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         h_inc_q       <= 1'b0;
         v_inc_q       <= 1'b0;
         src_tgl_q     <= 1'b0;
         en_tgl_q      <= 1'b0;
         slot_full_q   <= 1'b0;
         slot_cmd_q    <= CMD_H;
         stage_valid_q <= 1'b0;
         stage_h_q     <= '0;
         stage_v_q     <= '0;
         stage_src_q   <= 1'b0;
         stage_en_q    <= 1'b1;
         h_pat         <= '0;
         v_pat         <= '0;
         src_uart      <= 1'b0;
         vga_en        <= 1'b1;
         cfg_strobe    <= 1'b0;
      end else begin
         state_q       <= state_d;
         h_inc_q       <= h_inc_d;
         v_inc_q       <= v_inc_d;
         src_tgl_q     <= src_tgl_d;
         en_tgl_q      <= en_tgl_d;
         slot_full_q   <= slot_full_d;
         slot_cmd_q    <= slot_cmd_d;
         stage_valid_q <= in_apply;
         if (in_apply) begin
            stage_h_q   <= new_h;
            stage_v_q   <= new_v;
            stage_src_q <= new_src;
            stage_en_q  <= new_en;
         end
         if (stage_valid_q) begin
            h_pat    <= stage_h_q;
            v_pat    <= stage_v_q;
            src_uart <= stage_src_q;
            vga_en   <= stage_en_q;
         end
         cfg_strobe <= stage_valid_q;
      end
   end

endmodule

// File: tb/tb_color_cfg_sched.sv
// Self-checking bench for color_cfg_sched: directed scenarios plus random
// button/UART traffic against a frame-level reference model and scoreboard.
module tb_color_cfg_sched;
   import color_show_pkg::*;

   localparam int PW  = 3;
   localparam int MOD = 1 << PW;

   logic          clk = 1'b0;
   logic          rst, HS, VS, DF_UART, DF_VGA, frame_start, rx_valid;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic [PW-1:0] h_pat, v_pat;
   logic          src_uart, vga_en, cfg_strobe;

   color_cfg_sched #(.PAT_W(PW)) dut (
      .clk(clk), .rst(rst), .HS(HS), .VS(VS), .DF_UART(DF_UART), .DF_VGA(DF_VGA),
      .frame_start(frame_start), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready), .h_pat(h_pat), .v_pat(v_pat), .src_uart(src_uart),
      .vga_en(vga_en), .cfg_strobe(cfg_strobe)
   );

   always #5 clk = ~clk;

   typedef struct {
      int h;
      int v;
      bit src;
      bit en;
   } cfg_t;

   cfg_t exp_q[$];
   cfg_t mon_e;
   int   checks   = 0;
   int   failures = 0;

   // Reference model: architectural configuration plus pending requests.
   int         m_h, m_v;
   bit         m_src, m_en;
   bit         p_h, p_v, p_s, p_e;
   bit         m_slot;
   logic [7:0] m_cmd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0 && cfg_strobe === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("strobe_h_pat", 32'(h_pat), 32'(mon_e.h));
            check("strobe_v_pat", 32'(v_pat), 32'(mon_e.v));
            check("strobe_src_uart", 32'(src_uart), 32'(mon_e.src));
            check("strobe_vga_en", 32'(vga_en), 32'(mon_e.en));
         end
      end
   end

   function automatic bit is_cmd(input logic [7:0] b);
      return b == BYTE_H || b == BYTE_V || b == BYTE_U || b == BYTE_E || b == BYTE_R;
   endfunction

   task automatic model_reset();
      m_h = 0; m_v = 0; m_src = 0; m_en = 1;
      p_h = 0; p_v = 0; p_s = 0; p_e = 0;
      m_slot = 0; m_cmd = 8'h00;
      exp_q.delete();
   endtask

   // One frame boundary: buttons always win, the queued byte only if its field is free.
   task automatic model_frame();
      bit   conflict;
      cfg_t e;
      if (!(p_h || p_v || p_s || p_e || m_slot)) return;
      conflict = 0;
      if (m_slot) begin
         if (m_cmd == BYTE_H) conflict = p_h;
         if (m_cmd == BYTE_V) conflict = p_v;
         if (m_cmd == BYTE_U) conflict = p_s;
         if (m_cmd == BYTE_E) conflict = p_e;
         if (m_cmd == BYTE_R) conflict = p_h || p_v;
      end
      if (p_h) m_h = (m_h + 1) % MOD;
      if (p_v) m_v = (m_v + 1) % MOD;
      if (p_s) m_src = !m_src;
      if (p_e) m_en = !m_en;
      if (m_slot && !conflict) begin
         if (m_cmd == BYTE_H) m_h = (m_h + 1) % MOD;
         if (m_cmd == BYTE_V) m_v = (m_v + 1) % MOD;
         if (m_cmd == BYTE_U) m_src = !m_src;
         if (m_cmd == BYTE_E) m_en = !m_en;
         if (m_cmd == BYTE_R) begin m_h = 0; m_v = 0; end
         m_slot = 0;
      end
      p_h = 0; p_v = 0; p_s = 0; p_e = 0;
      e.h = m_h; e.v = m_v; e.src = m_src; e.en = m_en;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_btn(input int which);
      case (which)
         0: HS = 1'b1;
         1: VS = 1'b1;
         2: DF_UART = 1'b1;
         default: DF_VGA = 1'b1;
      endcase
      tick();
      HS = 1'b0; VS = 1'b0; DF_UART = 1'b0; DF_VGA = 1'b0;
      tick();
      case (which)
         0: p_h = 1;
         1: p_v = 1;
         2: p_s = 1;
         default: p_e = 1;
      endcase
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit accepted;
      check("rx_ready_before_byte", 32'(rx_ready), 32'(!m_slot));
      accepted = !m_slot;
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
      if (accepted && is_cmd(b)) begin
         m_slot = 1;
         m_cmd  = b;
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_h_pat"}, 32'(h_pat), 32'(m_h));
      check({tag, "_v_pat"}, 32'(v_pat), 32'(m_v));
      check({tag, "_src_uart"}, 32'(src_uart), 32'(m_src));
      check({tag, "_vga_en"}, 32'(vga_en), 32'(m_en));
      check({tag, "_rx_ready"}, 32'(rx_ready), 32'(!m_slot));
   endtask

   task automatic do_frame();
      repeat (3) tick();
      model_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (6) tick();
      check("strobe_seen", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      check_outputs("frame");
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      check("rst_h_pat", 32'(h_pat), 32'd0);
      check("rst_v_pat", 32'(v_pat), 32'd0);
      check("rst_src_uart", 32'(src_uart), 32'd0);
      check("rst_vga_en", 32'(vga_en), 32'd1);
      check("rst_cfg_strobe", 32'(cfg_strobe), 32'd0);
      check("rst_rx_ready", 32'(rx_ready), 32'd0);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check("post_rst_rx_ready", 32'(rx_ready), 32'd1);
      tick();
   endtask

   logic [7:0] byte_tab [7];

   initial begin
      byte_tab[0] = BYTE_H; byte_tab[1] = BYTE_V; byte_tab[2] = BYTE_U;
      byte_tab[3] = BYTE_E; byte_tab[4] = BYTE_R; byte_tab[5] = 8'h41;
      byte_tab[6] = 8'h00;
      HS = 0; VS = 0; DF_UART = 0; DF_VGA = 0;
      frame_start = 0; rx_valid = 0; rx_data = 8'h00; rst = 1;
      model_reset();
      tick();
      apply_reset();

      // Single HS press: exact update and strobe timing.
      pulse_btn(0);
      repeat (20) tick();
      model_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      check("t1_h_pat_unchanged", 32'(h_pat), 32'd0);
      check("t1_strobe_early", 32'(cfg_strobe), 32'd0);
      tick();
      check("t2_h_pat_updated", 32'(h_pat), 32'd1);
      check("t2_strobe_high", 32'(cfg_strobe), 32'd1);
      tick();
      check("t3_strobe_low", 32'(cfg_strobe), 32'd0);
      check("t3_state_idle", 32'(dut.state_q == ST_IDLE), 32'd1);
      check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

      // Repeated presses within one frame coalesce.
      pulse_btn(0); pulse_btn(0); pulse_btn(0);
      do_frame();
      check("coalesce_h_pat", 32'(h_pat), 32'd2);

      // Wrap from all-ones via a UART 'H'.
      while (m_h != MOD - 1) begin
         pulse_btn(0);
         do_frame();
      end
      send_byte(BYTE_H);
      check("slot_full_rx_ready", 32'(rx_ready), 32'd0);
      do_frame();
      check("wrap_h_pat", 32'(h_pat), 32'd0);
      check("wrap_rx_ready", 32'(rx_ready), 32'd1);

      // Button beats UART on the same field; command waits one frame.
      pulse_btn(2);
      send_byte(BYTE_U);
      do_frame();
      check("prio_src_uart", 32'(src_uart), 32'd1);
      check("prio_slot_held", 32'(rx_ready), 32'd0);
      do_frame();
      check("prio_src_back", 32'(src_uart), 32'd0);
      check("prio_rx_ready", 32'(rx_ready), 32'd1);

      // Unknown byte is swallowed; frame_start in IDLE produces nothing.
      send_byte(8'h41);
      check("junk_rx_ready", 32'(rx_ready), 32'd1);
      check("junk_state_idle", 32'(dut.state_q == ST_IDLE), 32'd1);
      do_frame();

      // Button held through reset, then reset while a VS request waits.
      HS = 1'b1;
      apply_reset();
      repeat (2) tick();
      HS = 1'b0;
      repeat (3) tick();
      check("held_state_idle", 32'(dut.state_q == ST_IDLE), 32'd1);
      pulse_btn(1);
      repeat (2) tick();
      check("vs_state_wait", 32'(dut.state_q == ST_WAIT_FRAME), 32'd1);
      apply_reset();
      do_frame();

      // Random traffic.
      for (int f = 0; f < 150; f++) begin
         int n;
         n = $urandom_range(0, 3);
         for (int k = 0; k < n; k++) begin
            int r;
            r = $urandom_range(0, 5);
            if (r < 4) pulse_btn(r);
            else if ($urandom_range(0, 7) == 0) send_byte(8'($urandom));
            else send_byte(byte_tab[$urandom_range(0, 6)]);
         end
         do_frame();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/color_cfg_sched.md
COLOR_CFG_SCHED -- requirements
Module: color_cfg_sched

Interface
REQ-001 The block SHALL have one parameter, PAT_W, default 3, giving the pattern index width (2**PAT_W patterns).
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 HS  input  1  debounced level of the horizontal-pattern button.
REQ-005 VS  input  1  debounced level of the vertical-pattern button.
REQ-006 DF_UART  input  1  debounced level of the UART-source toggle button.
REQ-007 DF_VGA  input  1  debounced level of the VGA-enable toggle button.
REQ-008 frame_start  input  1  one-cycle pulse at start of vertical blank.
REQ-009 rx_valid  input  1  UART byte strobe; rx_data SHALL be accepted when rx_valid and rx_ready are both high.
REQ-010 rx_data  input  8  received UART byte.
REQ-011 rx_ready  output  1  high when the single UART command slot is empty.
REQ-012 h_pat  output  PAT_W  active horizontal pattern index.
REQ-013 v_pat  output  PAT_W  active vertical pattern index.
REQ-014 src_uart  output  1  1 = colour data from UART, 0 = local generator.
REQ-015 vga_en  output  1  VGA output enable.
REQ-016 cfg_strobe  output  1  one-cycle pulse coincident with new configuration values.

Function
REQ-017 Each button input SHALL be rising-edge detected against a one-cycle-delayed copy; a rising edge SHALL set a sticky pending flag (h_inc, v_inc, src_tgl, en_tgl).
REQ-018 Repeated edges on one button before the next apply SHALL coalesce into one pending action.
REQ-019 Accepted bytes SHALL decode as: 0x48 'H' h_inc, 0x56 'V' v_inc, 0x55 'U' src_tgl, 0x45 'E' en_tgl, 0x52 'R' clear patterns; all other bytes SHALL be accepted and discarded without filling the slot.
REQ-020 A valid command SHALL occupy the slot; rx_ready SHALL be low while the slot is full.
REQ-021 FSM states: IDLE (nothing pending), WAIT_FRAME (button flag or slot pending), APPLY (one cycle).
REQ-022 Transitions: IDLE->WAIT_FRAME on any pending; WAIT_FRAME->APPLY when frame_start is sampled high; APPLY->WAIT_FRAME if anything remains pending after apply, else IDLE.
REQ-023 frame_start in IDLE or APPLY SHALL be ignored.
REQ-024 Outputs SHALL update at the second rising edge after the edge sampling frame_start; cfg_strobe SHALL be high for exactly the cycle following that update.
REQ-025 In APPLY all pending button flags SHALL be applied and cleared together.
REQ-026 Arbitration: the UART command SHALL be applied in the same APPLY only if no button flag targets the same field; otherwise it SHALL stay in the slot for the next frame (button priority).
REQ-027 'R' SHALL set h_pat and v_pat to 0 and conflict with h_inc or v_inc.
REQ-028 h_pat and v_pat SHALL increment modulo 2**PAT_W (all-ones wraps to 0).
REQ-029 Edges and bytes arriving during APPLY SHALL be captured as pending for the next frame, never lost.

Reset
REQ-030 During rst: h_pat=0, v_pat=0, src_uart=0, vga_en=1, cfg_strobe=0, rx_ready=0, slot empty, flags clear, state IDLE.
REQ-031 Edge registers SHALL load the current button levels during rst so a button held through reset produces no event.
REQ-032 rst asserted in any state SHALL discard all pending work at the next edge; rx_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-033 Package color_show_pkg SHALL hold UART command byte constants, FSM state enum and default PAT_W.
REQ-034 One sub-module, edge_rise (level in, one-cycle rising pulse out, reset-primed), SHALL be instantiated four times.

Verification
REQ-035 HS pulse, frame_start 20 cycles later -> h_pat 0->1 two edges after the frame_start edge, cfg_strobe one cycle, state IDLE.
REQ-036 Three HS pulses in one frame -> h_pat increments by exactly 1.
REQ-037 h_pat=7, 'H' byte, frame_start -> h_pat=0, rx_ready returns high.
REQ-038 DF_UART edge plus 'U' byte, one frame_start -> src_uart=1, slot still full; second frame_start -> src_uart=0, rx_ready=1.
REQ-039 0x41 byte -> accepted, rx_ready stays high, no state change; frame_start -> no cfg_strobe.
REQ-040 HS held high across rst, released, then rst during WAIT_FRAME with VS pending -> no h or v change, outputs at reset values.
